// File: rtl/fb_arbiter_pkg.sv
// Shared types and default geometry for the framebuffer arbiter slice.
package fb_pkg;

    localparam int FB_DEPTH  = 120000;  // 200x600 pixels
    localparam int FB_ADDR_W = 17;
    localparam int FB_PXL_W  = 3;       // one bit each for R, G, B

    // Who issued the access whose data is travelling back from the RAM.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_SC   = 2'd1,
        OWN_DR   = 2'd2
    } fb_owner_e;

    // Return tag: owner plus a flag forcing the returned pixel to 0.
    typedef struct packed {
        fb_owner_e owner;
        logic      oor;
    } fb_tag_t;

endpackage

// File: rtl/fb_arbiter_if.sv
// Bus bundle for the framebuffer arbiter: scanout port, draw port,
// RAM port and the starvation statistic.
interface fb_arbiter_if
    import fb_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W,
    parameter int PXL_W  = FB_PXL_W
);

    logic              blank;

    logic              sc_req;
    logic [ADDR_W-1:0] sc_addr;
    logic              sc_gnt;
    logic              sc_rvalid;
    logic [PXL_W-1:0]  sc_rdata;

    logic              dr_valid;
    logic              dr_we;
    logic [ADDR_W-1:0] dr_addr;
    logic [PXL_W-1:0]  dr_wdata;
    logic              dr_ready;
    logic              dr_rvalid;
    logic [PXL_W-1:0]  dr_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [PXL_W-1:0]  mem_wdata;
    logic [PXL_W-1:0]  mem_rdata;

    logic [15:0]       starve_events;

    // Arbiter side.
    modport slave (
        input  blank,
        input  sc_req, sc_addr,
        output sc_gnt, sc_rvalid, sc_rdata,
        input  dr_valid, dr_we, dr_addr, dr_wdata,
        output dr_ready, dr_rvalid, dr_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output starve_events
    );

    // Requester / RAM environment side.
    modport master (
        output blank,
        output sc_req, sc_addr,
        input  sc_gnt, sc_rvalid, sc_rdata,
        output dr_valid, dr_we, dr_addr, dr_wdata,
        input  dr_ready, dr_rvalid, dr_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  starve_events
    );

endinterface

// File: rtl/fb_arbiter_rd_pipe.sv
// Read-return pipeline: carries the owner tag alongside the RAM access
// and steers the returned pixel to the scanout or draw read port.
module fb_rd_pipe
    import fb_pkg::*;
#(
    parameter int PXL_W = FB_PXL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  fb_tag_t          tag_in,
    input  logic [PXL_W-1:0] mem_rdata,
    output logic             sc_rvalid,
    output logic [PXL_W-1:0] sc_rdata,
    output logic             dr_rvalid,
    output logic [PXL_W-1:0] dr_rdata
);

    localparam fb_tag_t TAG_IDLE = '{owner: OWN_NONE, oor: 1'b0};

    fb_tag_t          tag_p0;
    fb_tag_t          tag_p1;
    logic [PXL_W-1:0] ret_data;

    // Stage boundary: tag_p0 aligns with mem_en, tag_p1 with mem_rdata.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_p0 <= TAG_IDLE;
            tag_p1 <= TAG_IDLE;
        end else begin
            tag_p0 <= tag_in;
            tag_p1 <= tag_p0;
        end
    end

    // Out-of-range reads never touched the RAM, so they return 0.
    assign ret_data = tag_p1.oor ? '0 : mem_rdata;

    // Stage boundary: register the routed data onto the owner's return port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sc_rvalid <= 1'b0;
            sc_rdata  <= '0;
            dr_rvalid <= 1'b0;
            dr_rdata  <= '0;
        end else begin
            sc_rvalid <= (tag_p1.owner == OWN_SC);
            dr_rvalid <= (tag_p1.owner == OWN_DR);
            if (tag_p1.owner == OWN_SC) begin
                sc_rdata <= ret_data;
            end
            if (tag_p1.owner == OWN_DR) begin
                dr_rdata <= ret_data;
            end
        end
    end

endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: scanout owns the RAM during active
// video, the draw engine during blanking, with a starvation guard that
// forces a draw slot after STARVE_LIMIT consecutive lost cycles.
module fb_arbiter
    import fb_pkg::*;
#(
    parameter int FB_DEPTH     = fb_pkg::FB_DEPTH,
    parameter int ADDR_W       = FB_ADDR_W,
    parameter int PXL_W        = FB_PXL_W,
    parameter int STARVE_LIMIT = 8
) (
    input  logic         clk,
    input  logic         rst,
    fb_arbiter_if.slave  bus
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0]        starve_cnt;
    logic [15:0]       starve_events;
    logic              sc_win;
    logic              dr_win;
    logic              forced;
    logic [ADDR_W-1:0] acc_addr;
    logic              acc_oor;
    fb_tag_t           acc_tag;

    logic              mem_en_p0;
    logic              mem_we_p0;
    logic [ADDR_W-1:0] mem_addr_p0;
    logic [PXL_W-1:0]  mem_wdata_p0;

    function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
        return 32'(a) >= 32'(FB_DEPTH);
    endfunction

    // Winner selection; blank acts combinationally in the same cycle.
    always_comb begin
        sc_win = 1'b0;
        dr_win = 1'b0;
        forced = 1'b0;
        if (bus.sc_req && bus.dr_valid) begin
            if (bus.blank) begin
                dr_win = 1'b1;
            end else if (starve_cnt == LIMIT) begin
                dr_win = 1'b1;
                forced = 1'b1;
            end else begin
                sc_win = 1'b1;
            end
        end else begin
            sc_win = bus.sc_req;
            dr_win = bus.dr_valid;
        end
    end

    assign bus.sc_gnt   = sc_win;
    assign bus.dr_ready = dr_win;

    // Accepted access: address mux, range check and return tag.
    always_comb begin
        acc_addr      = dr_win ? bus.dr_addr : bus.sc_addr;
        acc_oor       = out_of_range(acc_addr);
        acc_tag.oor   = acc_oor;
        acc_tag.owner = OWN_NONE;
        if (sc_win) begin
            acc_tag.owner = OWN_SC;
        end else if (dr_win && !bus.dr_we) begin
            acc_tag.owner = OWN_DR;
        end
    end

    // Starvation counter and saturating forced-grant statistic.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt    <= '0;
            starve_events <= '0;
        end else begin
            if (!bus.dr_valid || dr_win) begin
                starve_cnt <= '0;
            end else if (starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + 8'd1;
            end
            if (forced && starve_events != 16'hFFFF) begin
                starve_events <= starve_events + 16'd1;
            end
        end
    end

    assign bus.starve_events = starve_events;

    // Stage boundary: register the RAM strobe; out-of-range accesses stay off the RAM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_en_p0    <= 1'b0;
            mem_we_p0    <= 1'b0;
            mem_addr_p0  <= '0;
            mem_wdata_p0 <= '0;
        end else begin
            mem_en_p0 <= (sc_win || dr_win) && !acc_oor;
            mem_we_p0 <= dr_win && bus.dr_we && !acc_oor;
            if (sc_win || dr_win) begin
                mem_addr_p0  <= acc_addr;
                mem_wdata_p0 <= bus.dr_wdata;
            end
        end
    end

    assign bus.mem_en    = mem_en_p0;
    assign bus.mem_we    = mem_we_p0;
    assign bus.mem_addr  = mem_addr_p0;
    assign bus.mem_wdata = mem_wdata_p0;

    fb_rd_pipe #(
        .PXL_W (PXL_W)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .tag_in    (acc_tag),
        .mem_rdata (bus.mem_rdata),
        .sc_rvalid (bus.sc_rvalid),
        .sc_rdata  (bus.sc_rdata),
        .dr_rvalid (bus.dr_rvalid),
        .dr_rdata  (bus.dr_rdata)
    );

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with a behavioural synchronous pixel RAM.
module tb_fb_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [2:0] pix [3] = '{3'b011, 3'b110, 3'b001};

    fb_arbiter_if #(.ADDR_W(17), .PXL_W(3)) bus ();

    fb_arbiter #(
        .FB_DEPTH     (120000),
        .ADDR_W       (17),
        .PXL_W        (3),
        .STARVE_LIMIT (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Pixel RAM model: read data valid the cycle after mem_en; preloaded in reset.
    logic [2:0] ram [0:131071];
    always @(posedge clk) begin
        if (!rst) begin
            ram[5]      <= 3'b011;
            ram[6]      <= 3'b110;
            ram[7]      <= 3'b001;
            ram[120000] <= 3'b111;
        end else if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.blank    = 1'b0;
        bus.sc_req   = 1'b0;
        bus.sc_addr  = '0;
        bus.dr_valid = 1'b0;
        bus.dr_we    = 1'b0;
        bus.dr_addr  = '0;
        bus.dr_wdata = '0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_en",    32'(bus.mem_en), 0);
        check("rst_mem_we",    32'(bus.mem_we), 0);
        check("rst_mem_addr",  32'(bus.mem_addr), 0);
        check("rst_mem_wdata", 32'(bus.mem_wdata), 0);
        check("rst_sc_rvalid", 32'(bus.sc_rvalid), 0);
        check("rst_dr_rvalid", 32'(bus.dr_rvalid), 0);
        check("rst_sc_rdata",  32'(bus.sc_rdata), 0);
        check("rst_dr_rdata",  32'(bus.dr_rdata), 0);
        check("rst_events",    32'(bus.starve_events), 0);
        next_cycle();
        rst = 1'b1;

        // Idle for 10 cycles
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("idle_sc_gnt",   32'(bus.sc_gnt), 0);
            check("idle_dr_ready", 32'(bus.dr_ready), 0);
            check("idle_mem_en",   32'(bus.mem_en), 0);
            check("idle_rvalid",   32'({bus.sc_rvalid, bus.dr_rvalid}), 0);
            next_cycle();
        end

        // Scanout alone: back-to-back reads at 5, 6, 7
        for (int k = 0; k < 7; k++) begin
            if (k < 3) begin
                bus.sc_req  = 1'b1;
                bus.sc_addr = 17'(5 + k);
            end else begin
                bus.sc_req = 1'b0;
            end
            @(negedge clk);
            if (k < 3) check("sc_gnt", 32'(bus.sc_gnt), 1);
            check("sc_mem_en", 32'(bus.mem_en), 32'(k >= 1 && k <= 3));
            if (k >= 1 && k <= 3) check("sc_mem_addr", 32'(bus.mem_addr), 32'(4 + k));
            check("sc_rvalid", 32'(bus.sc_rvalid), 32'(k >= 3 && k <= 5));
            if (k >= 3 && k <= 5) check("sc_rdata", 32'(bus.sc_rdata), 32'(pix[k-3]));
            check("sc_dr_rvalid", 32'(bus.dr_rvalid), 0);
            next_cycle();
        end

        // Both requesting in active video: draw forced every 9th cycle
        bus.sc_req   = 1'b1;
        bus.sc_addr  = 17'd10;
        bus.dr_valid = 1'b1;
        bus.dr_we    = 1'b1;
        bus.dr_addr  = 17'd200;
        bus.dr_wdata = 3'b001;
        for (int k = 0; k < 27; k++) begin
            @(negedge clk);
            check("stv_dr_ready", 32'(bus.dr_ready), 32'(k % 9 == 8));
            check("stv_sc_gnt",   32'(bus.sc_gnt),   32'(k % 9 != 8));
            check("stv_events",   32'(bus.starve_events), 32'(k / 9));
            next_cycle();
        end
        bus.sc_req   = 1'b0;
        bus.dr_valid = 1'b0;
        @(negedge clk);
        check("stv_events_end", 32'(bus.starve_events), 3);
        repeat (4) next_cycle();

        // Blanking: draw write wins, scanout read follows once draw drops
        bus.blank    = 1'b1;
        bus.sc_req   = 1'b1;
        bus.sc_addr  = 17'd100;
        bus.dr_valid = 1'b1;
        bus.dr_we    = 1'b1;
        bus.dr_addr  = 17'd100;
        bus.dr_wdata = 3'b101;
        @(negedge clk);
        check("blk_dr_ready", 32'(bus.dr_ready), 1);
        check("blk_sc_gnt0",  32'(bus.sc_gnt), 0);
        next_cycle();
        bus.dr_valid = 1'b0;
        @(negedge clk);
        check("blk_sc_gnt1",    32'(bus.sc_gnt), 1);
        check("blk_mem_en",     32'(bus.mem_en), 1);
        check("blk_mem_we",     32'(bus.mem_we), 1);
        check("blk_mem_addr",   32'(bus.mem_addr), 100);
        check("blk_mem_wdata",  32'(bus.mem_wdata), 32'b101);
        next_cycle();
        bus.sc_req = 1'b0;
        @(negedge clk);
        check("blk_rd_mem_en", 32'(bus.mem_en), 1);
        check("blk_rd_mem_we", 32'(bus.mem_we), 0);
        next_cycle();
        @(negedge clk);
        check("blk_no_rvalid", 32'(bus.sc_rvalid), 0);
        next_cycle();
        @(negedge clk);
        check("blk_sc_rvalid", 32'(bus.sc_rvalid), 1);
        check("blk_sc_rdata",  32'(bus.sc_rdata), 32'b101);
        next_cycle();
        bus.blank = 1'b0;
        repeat (2) next_cycle();

        // Draw reads back-to-back: in range (6), then out of range (120000)
        bus.dr_valid = 1'b1;
        bus.dr_we    = 1'b0;
        bus.dr_addr  = 17'd6;
        @(negedge clk);
        check("dr_ready_in", 32'(bus.dr_ready), 1);
        next_cycle();
        bus.dr_addr = 17'd120000;
        @(negedge clk);
        check("dr_ready_oor", 32'(bus.dr_ready), 1);
        check("dr_mem_en_in", 32'(bus.mem_en), 1);
        check("dr_mem_addr",  32'(bus.mem_addr), 6);
        next_cycle();
        bus.dr_valid = 1'b0;
        @(negedge clk);
        check("oor_mem_en2", 32'(bus.mem_en), 0);
        check("dr_rvalid2",  32'(bus.dr_rvalid), 0);
        next_cycle();
        @(negedge clk);
        check("oor_mem_en3", 32'(bus.mem_en), 0);
        check("dr_rvalid3",  32'(bus.dr_rvalid), 1);
        check("dr_rdata3",   32'(bus.dr_rdata), 32'b110);
        check("dr_sc_rvalid", 32'(bus.sc_rvalid), 0);
        next_cycle();
        @(negedge clk);
        check("oor_rvalid", 32'(bus.dr_rvalid), 1);
        check("oor_rdata",  32'(bus.dr_rdata), 0);
        next_cycle();
        @(negedge clk);
        check("oor_rvalid_end", 32'(bus.dr_rvalid), 0);
        next_cycle();

        // Reset with two scanout reads in flight
        bus.sc_req  = 1'b1;
        bus.sc_addr = 17'd5;
        @(negedge clk);
        check("rr_sc_gnt", 32'(bus.sc_gnt), 1);
        next_cycle();
        bus.sc_addr = 17'd6;
        #2;
        rst = 1'b0;
        @(negedge clk);
        check("rr_mem_en_rst", 32'(bus.mem_en), 0);
        next_cycle();
        bus.sc_req = 1'b0;
        @(negedge clk);
        check("rr_mem_en_rst2", 32'(bus.mem_en), 0);
        check("rr_events_rst",  32'(bus.starve_events), 0);
        next_cycle();
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("rr_sc_rvalid", 32'(bus.sc_rvalid), 0);
            check("rr_mem_en",    32'(bus.mem_en), 0);
            next_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
